port_c_gpio: RTL and testbench

- 7-bit GPIO Port C (PC6..PC0) for the ATmega328PB-compatible 8-bit MCU core.
- Holds the PORTC, DDRC and PINC I/O registers and sits on the core I/O bus.
- Combines the register settings with alternate-function overrides (RESET, TWI0, SPI1, ADC, PCINT) and drives per-pin pad controls.
- Forwards pad input values to the digital-input consumers.

---
 rtl/port_c_gpio_if.sv | 26 ++
 rtl/port_c_gpio.sv | 180 ++++++++++++++++++
 tb/tb_port_c_gpio.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/port_c_gpio_if.sv
// I/O bus bundle between the MCU core and the Port C register block.
//   IO_Addr  : 6-bit I/O address
//   iore     : read strobe
//   iowe     : write strobe
//   dbus_in  : write data from the core
//   dbus_out : read data to the core
//   out_en   : read data valid / bus drive enable
// Modports: master (core side), slave (peripheral side).
interface port_c_gpio_if;
  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;

  modport master (
    output IO_Addr, iore, iowe, dbus_in,
    input  dbus_out, out_en
  );

  modport slave (
    input  IO_Addr, iore, iowe, dbus_in,
    output dbus_out, out_en
  );
endinterface

// File: rtl/port_c_gpio.sv
// Port C GPIO (PC6..PC0) for an ATmega328PB-compatible core.
// Holds PORTC/DDRC, serves PINC reads, merges register settings with the RESET, TWI0, SPI1,
// ADC and PCINT alternate-function overrides and drives the per-pin pad controls.
// Ports:
//   cp2, ireset          : clock (rising edge), asynchronous active-high reset
//   bus                  : I/O bus (address, read/write strobes, data in/out, out_en)
//   pinC_i / DIC_o       : pad input values / gated digital input to peripherals
//   pu_C, dd_C, pv_C     : pull-up enable, output driver enable, output value per pin
//   die_C                : digital input enable per pin
//   PUD, SLEEP           : global pull-up disable, sleep state
//   RSTDISBL, TWEN0, SPE1, MSTR, SCK1_OUT, SPI1_SL_OUT, SCL0_OUT, SDA0_OUT,
//   ADCxD, PCINT, PCIE1  : alternate-function controls
// Optional macro PORTC_PIN_SYNC_EN: adds a 2-flop synchronizer on the PINC read path.
module port_c_gpio #(
  parameter logic [5:0] ADDR_PINC  = 6'h06,
  parameter logic [5:0] ADDR_DDRC  = 6'h07,
  parameter logic [5:0] ADDR_PORTC = 6'h08
) (
  input  logic          cp2,
  input  logic          ireset,
  port_c_gpio_if.slave  bus,
  input  logic [6:0]    pinC_i,
  output logic [6:0]    DIC_o,
  output logic [6:0]    pu_C,
  output logic [6:0]    dd_C,
  output logic [6:0]    pv_C,
  output logic [6:0]    die_C,
  input  logic          PUD,
  input  logic          SLEEP,
  input  logic          RSTDISBL,
  input  logic          TWEN0,
  input  logic          SPE1,
  input  logic          MSTR,
  input  logic          SCK1_OUT,
  input  logic          SPI1_SL_OUT,
  input  logic          SCL0_OUT,
  input  logic          SDA0_OUT,
  input  logic [5:0]    ADCxD,
  input  logic [6:0]    PCINT,
  input  logic          PCIE1
);

  logic [6:0] portc_q, portc_d;
  logic [6:0] ddrc_q, ddrc_d;
  logic [6:0] pin_rd;

  // Register writes; a 1 written to PINC toggles the matching PORTC bit.
  always_comb begin
    portc_d = portc_q;
    ddrc_d  = ddrc_q;
    if (bus.iowe) begin
      case (bus.IO_Addr)
        ADDR_PORTC: portc_d = bus.dbus_in[6:0];
        ADDR_PINC:  portc_d = portc_q ^ bus.dbus_in[6:0];
        ADDR_DDRC:  ddrc_d  = bus.dbus_in[6:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      portc_q <= 7'h00;
      ddrc_q  <= 7'h00;
    end else begin
      portc_q <= portc_d;
      ddrc_q  <= ddrc_d;
    end
  end

  // Alternate-function override / value terms per pin.
  logic [6:0] puoe, puov, ddoe, ddov, pvoe, pvov, dieoe, dieov;
  logic [6:0] pc_en;

  assign pc_en = PCINT & {7{PCIE1}};

  always_comb begin
    puoe  = '0;
    puov  = '0;
    ddoe  = '0;
    ddov  = '0;
    pvoe  = '0;
    pvov  = '0;
    dieoe = '0;
    dieov = '0;

    // PC6: RESET pin; once disabled the pin keeps a pull-up and stays an input.
    puoe[6]  = RSTDISBL;
    ddoe[6]  = RSTDISBL;
    puov[6]  = 1'b1;
    ddov[6]  = 1'b0;
    dieoe[6] = RSTDISBL | pc_en[6];
    dieov[6] = RSTDISBL;

    // PC5/PC4: TWI0 SCL/SDA, open-drain style driven from the TWI block.
    puoe[5] = TWEN0;
    ddoe[5] = TWEN0;
    pvoe[5] = TWEN0;
    puov[5] = portc_q[5] & ~PUD;
    ddov[5] = 1'b1;
    pvov[5] = SCL0_OUT;
    puoe[4] = TWEN0;
    ddoe[4] = TWEN0;
    pvoe[4] = TWEN0;
    puov[4] = portc_q[4] & ~PUD;
    ddov[4] = 1'b1;
    pvov[4] = SDA0_OUT;

    // PC1: SCK1 (output in master, forced input in slave).
    puoe[1] = SPE1 & ~MSTR;
    ddoe[1] = SPE1 & ~MSTR;
    puov[1] = portc_q[1] & ~PUD;
    ddov[1] = 1'b0;
    pvoe[1] = SPE1 & MSTR;
    pvov[1] = SCK1_OUT;

    // PC0: MISO1 (output in slave, forced input in master).
    puoe[0] = SPE1 & MSTR;
    ddoe[0] = SPE1 & MSTR;
    puov[0] = portc_q[0] & ~PUD;
    ddov[0] = 1'b0;
    pvoe[0] = SPE1 & ~MSTR;
    pvov[0] = SPI1_SL_OUT;

    // PC5..PC0: ADC disables the digital input unless a pin-change interrupt needs it.
    dieoe[5:0] = ADCxD | pc_en[5:0];
    dieov[5:0] = pc_en[5:0];
  end

  assign pu_C  = (puoe & puov) | (~puoe & portc_q & ~ddrc_q & {7{~PUD}});
  assign dd_C  = (ddoe & ddov) | (~ddoe & ddrc_q);
  assign pv_C  = (pvoe & pvov) | (~pvoe & portc_q);
  assign die_C = (dieoe & dieov) | (~dieoe & {7{~SLEEP}});
  assign DIC_o = pinC_i & die_C;

`ifdef PORTC_PIN_SYNC_EN
  logic [6:0] sync1_q, sync2_q;

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      sync1_q <= 7'h00;
      sync2_q <= 7'h00;
    end else begin
      sync1_q <= DIC_o;
      sync2_q <= sync1_q;
    end
  end

  assign pin_rd = sync2_q;
`else
  assign pin_rd = DIC_o;
`endif

  // Combinational read; returns pre-edge register contents during a same-cycle write.
  always_comb begin
    bus.out_en   = 1'b0;
    bus.dbus_out = 8'h00;
    if (bus.iore) begin
      case (bus.IO_Addr)
        ADDR_PINC: begin
          bus.out_en   = 1'b1;
          bus.dbus_out = {1'b0, pin_rd};
        end
        ADDR_DDRC: begin
          bus.out_en   = 1'b1;
          bus.dbus_out = {1'b0, ddrc_q};
        end
        ADDR_PORTC: begin
          bus.out_en   = 1'b1;
          bus.dbus_out = {1'b0, portc_q};
        end
        default: ;
      endcase
    end
  end

  logic unused_dbus_msb;
  assign unused_dbus_msb = bus.dbus_in[7];

endmodule

// File: tb/tb_port_c_gpio.sv
// Directed self-checking bench for port_c_gpio.
module tb_port_c_gpio;

  localparam logic [5:0] A_PINC  = 6'h06;
  localparam logic [5:0] A_DDRC  = 6'h07;
  localparam logic [5:0] A_PORTC = 6'h08;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [6:0] pinC_i, DIC_o, pu_C, dd_C, pv_C, die_C;
  logic       PUD, SLEEP, RSTDISBL, TWEN0, SPE1, MSTR;
  logic       SCK1_OUT, SPI1_SL_OUT, SCL0_OUT, SDA0_OUT, PCIE1;
  logic [5:0] ADCxD;
  logic [6:0] PCINT;

  int checks = 0;
  int errors = 0;

  port_c_gpio_if bus_if ();

  port_c_gpio dut (
    .cp2         (cp2),
    .ireset      (ireset),
    .bus         (bus_if),
    .pinC_i      (pinC_i),
    .DIC_o       (DIC_o),
    .pu_C        (pu_C),
    .dd_C        (dd_C),
    .pv_C        (pv_C),
    .die_C       (die_C),
    .PUD         (PUD),
    .SLEEP       (SLEEP),
    .RSTDISBL    (RSTDISBL),
    .TWEN0       (TWEN0),
    .SPE1        (SPE1),
    .MSTR        (MSTR),
    .SCK1_OUT    (SCK1_OUT),
    .SPI1_SL_OUT (SPI1_SL_OUT),
    .SCL0_OUT    (SCL0_OUT),
    .SDA0_OUT    (SDA0_OUT),
    .ADCxD       (ADCxD),
    .PCINT       (PCINT),
    .PCIE1       (PCIE1)
  );

  always #5 cp2 = ~cp2;

  task automatic wr(input logic [5:0] addr, input logic [7:0] data);
    @(negedge cp2);
    bus_if.IO_Addr = addr;
    bus_if.dbus_in = data;
    bus_if.iowe    = 1'b1;
    @(posedge cp2);
    #1;
    bus_if.iowe = 1'b0;
  endtask

  task automatic rd(input logic [5:0] addr);
    bus_if.IO_Addr = addr;
    bus_if.iore    = 1'b1;
    #1;
  endtask

  task automatic clear_alt();
    PUD = 0; SLEEP = 0; RSTDISBL = 0; TWEN0 = 0; SPE1 = 0; MSTR = 0;
    SCK1_OUT = 0; SPI1_SL_OUT = 0; SCL0_OUT = 0; SDA0_OUT = 0;
    ADCxD = 6'h00; PCINT = 7'h00; PCIE1 = 0;
    #1;
  endtask

  task automatic test_reset();
    ireset = 1'b1;
    bus_if.iore = 1'b0; bus_if.iowe = 1'b0;
    bus_if.IO_Addr = 6'h00; bus_if.dbus_in = 8'h00;
    pinC_i = 7'h00;
    clear_alt();
    repeat (2) @(posedge cp2);
    #1;
    checks++;
    if (pu_C !== 7'h00 || dd_C !== 7'h00 || pv_C !== 7'h00) begin
      errors++;
      $display("FAIL reset_pads: pu=%h dd=%h pv=%h, required 00 00 00", pu_C, dd_C, pv_C);
    end
    checks++;
    if (die_C !== 7'h7F) begin
      errors++;
      $display("FAIL reset_die: got %h, required 7f", die_C);
    end
    checks++;
    if (bus_if.out_en !== 1'b0 || bus_if.dbus_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: out_en=%b dbus_out=%h, required 0 00",
               bus_if.out_en, bus_if.dbus_out);
    end
    @(negedge cp2);
    ireset = 1'b0;
  endtask

  task automatic test_pullup();
    wr(A_DDRC, 8'h00);
    wr(A_PORTC, 8'h7F);
    #1;
    checks++;
    if (pu_C !== 7'h7F || dd_C !== 7'h00 || pv_C !== 7'h7F) begin
      errors++;
      $display("FAIL pullup_on: pu=%h dd=%h pv=%h, required 7f 00 7f", pu_C, dd_C, pv_C);
    end
    PUD = 1'b1;
    #1;
    checks++;
    if (pu_C !== 7'h00) begin
      errors++;
      $display("FAIL pullup_pud: got %h, required 00", pu_C);
    end
    PUD = 1'b0;
    wr(A_DDRC, 8'h0F);
    #1;
    checks++;
    if (pu_C !== 7'h70 || dd_C !== 7'h0F) begin
      errors++;
      $display("FAIL pullup_ddr: pu=%h dd=%h, required 70 0f", pu_C, dd_C);
    end
  endtask

  task automatic test_pinc_toggle();
    wr(A_DDRC, 8'h7F);
    wr(A_PORTC, 8'h00);
    wr(A_PINC, 8'h0F);
    #1;
    checks++;
    if (pv_C !== 7'h0F) begin
      errors++;
      $display("FAIL toggle_pv: got %h, required 0f", pv_C);
    end
    rd(A_PORTC);
    checks++;
    if (bus_if.out_en !== 1'b1 || bus_if.dbus_out !== 8'h0F) begin
      errors++;
      $display("FAIL toggle_read: out_en=%b dbus_out=%h, required 1 0f",
               bus_if.out_en, bus_if.dbus_out);
    end
    bus_if.iore = 1'b0;
    wr(A_PINC, 8'h83);
    rd(A_PORTC);
    checks++;
    if (bus_if.dbus_out !== 8'h0C) begin
      errors++;
      $display("FAIL toggle_second: got %h, required 0c", bus_if.dbus_out);
    end
    rd(A_DDRC);
    checks++;
    if (bus_if.out_en !== 1'b1 || bus_if.dbus_out !== 8'h7F) begin
      errors++;
      $display("FAIL read_ddrc: out_en=%b dbus_out=%h, required 1 7f",
               bus_if.out_en, bus_if.dbus_out);
    end
    bus_if.iore = 1'b0;
    wr(A_PORTC, 8'hFF);
    rd(A_PORTC);
    checks++;
    if (bus_if.dbus_out !== 8'h7F) begin
      errors++;
      $display("FAIL bit7_ignored: got %h, required 7f", bus_if.dbus_out);
    end
    bus_if.iore = 1'b0;
  endtask

  task automatic test_alt_dir();
    wr(A_DDRC, 8'h00);
    wr(A_PORTC, 8'h7F);
    RSTDISBL = 1; TWEN0 = 1; SPE1 = 1; MSTR = 0; PUD = 0;
    #1;
    checks++;
    if (pu_C[6:4] !== 3'b111 || pu_C[1] !== 1'b1) begin
      errors++;
      $display("FAIL alt_pullup: got %h, required [6:4]=111 [1]=1", pu_C);
    end
    checks++;
    if (dd_C[6] !== 1'b0 || dd_C[5:4] !== 2'b11 || dd_C[1] !== 1'b0 || dd_C[0] !== 1'b0) begin
      errors++;
      $display("FAIL alt_ddr: got %h, required 30", dd_C);
    end
    PUD = 1;
    #1;
    checks++;
    if (pu_C !== 7'h40) begin
      errors++;
      $display("FAIL alt_pud: got %h, required 40", pu_C);
    end
    clear_alt();
  endtask

  task automatic test_alt_value();
    wr(A_DDRC, 8'h7F);
    wr(A_PORTC, 8'h7F);
    TWEN0 = 1; SPE1 = 1; MSTR = 1;
    SCL0_OUT = 0; SDA0_OUT = 0; SCK1_OUT = 0;
    #1;
    checks++;
    if (pv_C !== 7'h4D) begin
      errors++;
      $display("FAIL alt_pv_low: got %h, required 4d", pv_C);
    end
    SCL0_OUT = 1; SDA0_OUT = 1; SCK1_OUT = 1;
    #1;
    checks++;
    if (pv_C !== 7'h7F) begin
      errors++;
      $display("FAIL alt_pv_high: got %h, required 7f", pv_C);
    end
    MSTR = 0; SPI1_SL_OUT = 0;
    #1;
    checks++;
    if (pv_C[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL alt_pv_slave: got %b, required 10", pv_C[1:0]);
    end
    clear_alt();
  endtask

  task automatic test_die();
    SLEEP = 0;
    #1;
    checks++;
    if (die_C !== 7'h7F) begin
      errors++;
      $display("FAIL die_awake: got %h, required 7f", die_C);
    end
    SLEEP = 1;
    #1;
    checks++;
    if (die_C !== 7'h00) begin
      errors++;
      $display("FAIL die_sleep: got %h, required 00", die_C);
    end
    SLEEP = 0; ADCxD = 6'h3F;
    #1;
    checks++;
    if (die_C !== 7'h40) begin
      errors++;
      $display("FAIL die_adc: got %h, required 40", die_C);
    end
    ADCxD = 6'h00; PCINT = 7'h7F; PCIE1 = 1; SLEEP = 1; RSTDISBL = 1;
    #1;
    checks++;
    if (die_C !== 7'h7F) begin
      errors++;
      $display("FAIL die_pcint: got %h, required 7f", die_C);
    end
    clear_alt();
  endtask

  task automatic test_pin_read();
    pinC_i = 7'h00;
    repeat (3) @(posedge cp2);
    @(negedge cp2);
    pinC_i = 7'h55;
    rd(A_PINC);
    checks++;
    if (DIC_o !== 7'h55) begin
      errors++;
      $display("FAIL dic: got %h, required 55", DIC_o);
    end
`ifdef PORTC_PIN_SYNC_EN
    checks++;
    if (bus_if.dbus_out !== 8'h00) begin
      errors++;
      $display("FAIL pinc_early: got %h, required 00", bus_if.dbus_out);
    end
    @(posedge cp2);
    #1;
    checks++;
    if (bus_if.dbus_out !== 8'h00) begin
      errors++;
      $display("FAIL pinc_one_cycle: got %h, required 00", bus_if.dbus_out);
    end
    @(posedge cp2);
    #1;
`endif
    checks++;
    if (bus_if.out_en !== 1'b1 || bus_if.dbus_out !== 8'h55) begin
      errors++;
      $display("FAIL pinc_read: out_en=%b dbus_out=%h, required 1 55",
               bus_if.out_en, bus_if.dbus_out);
    end
    SLEEP = 1;
    #1;
    checks++;
    if (DIC_o !== 7'h00) begin
      errors++;
      $display("FAIL dic_sleep: got %h, required 00", DIC_o);
    end
    SLEEP = 0;
    rd(6'h09);
    checks++;
    if (bus_if.out_en !== 1'b0 || bus_if.dbus_out !== 8'h00) begin
      errors++;
      $display("FAIL unmapped: out_en=%b dbus_out=%h, required 0 00",
               bus_if.out_en, bus_if.dbus_out);
    end
    bus_if.iore = 1'b0;
  endtask

  task automatic test_back_to_back();
    wr(A_PORTC, 8'h11);
    @(negedge cp2);
    bus_if.IO_Addr = A_PORTC;
    bus_if.dbus_in = 8'h22;
    bus_if.iowe    = 1'b1;
    bus_if.iore    = 1'b1;
    #1;
    checks++;
    if (bus_if.dbus_out !== 8'h11) begin
      errors++;
      $display("FAIL rw_same_pre: got %h, required 11", bus_if.dbus_out);
    end
    @(posedge cp2);
    #1;
    bus_if.iowe = 1'b0;
    #1;
    checks++;
    if (bus_if.dbus_out !== 8'h22) begin
      errors++;
      $display("FAIL rw_same_post: got %h, required 22", bus_if.dbus_out);
    end
    bus_if.iore = 1'b0;
  endtask

  task automatic test_async_reset();
    wr(A_DDRC, 8'h7F);
    wr(A_PORTC, 8'h2A);
    @(negedge cp2);
    #2;
    ireset = 1'b1;
    #1;
    checks++;
    if (pv_C !== 7'h00 || dd_C !== 7'h00) begin
      errors++;
      $display("FAIL async_reset: pv=%h dd=%h, required 00 00", pv_C, dd_C);
    end
    @(negedge cp2);
    ireset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pullup();
    test_pinc_toggle();
    test_alt_dir();
    test_alt_value();
    test_die();
    test_pin_read();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
